// File: rtl/var_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : var_delay_ctrl
// Description : Calibration controller for the variable clock-delay cell.
//               On start it sweeps delay_sel through leading (0), origin (1)
//               and lagging (2). At each setting it waits SETTLE_CYC cycles,
//               then counts MEAS_LEN valid samples from the receive-data
//               error checker and accumulates the errors seen. It then locks
//               delay_sel to the setting with the fewest errors (ties prefer
//               origin, then leading, then lagging).
//
//               Optional macro VAR_DELAY_TRACK_EN: while LOCKED, errors are
//               counted in windows of MEAS_LEN valid samples. A window with
//               more than ERR_THR errors restarts the sweep automatically.
//
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               start      - calibration request (honoured in IDLE/LOCKED)
//               abort      - cancel calibration, wins over start
//               sample_vld - checker has a sample result this cycle
//               sample_err - sample mismatched, qualified by sample_vld
//               mode       - 1 = delay cell honours delay_sel, 0 = origin
//               delay_sel  - 0 leading, 1 origin, 2 lagging
//               busy       - sweep in progress
//               done       - one-cycle pulse when the decision is made
//               locked     - best setting applied
//               best_sel   - chosen setting
//               err_lead / err_orig / err_lag - errors per setting
//
// Revision    : 1.0 - initial release
// ============================================================================
module var_delay_ctrl #(
    parameter int SETTLE_CYC = 8,
    parameter int MEAS_LEN   = 256,
    parameter int ERR_THR    = 4,
    localparam int CNT_W     = $clog2(MEAS_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             sample_vld,
    input  logic             sample_err,
    output logic             mode,
    output logic [1:0]       delay_sel,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic [1:0]       best_sel,
    output logic [CNT_W-1:0] err_lead,
    output logic [CNT_W-1:0] err_orig,
    output logic [CNT_W-1:0] err_lag
);

    localparam int c_settle_w = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYC - 1);
    localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);
    localparam logic [CNT_W-1:0]      c_meas_last   = CNT_W'(MEAS_LEN - 1);
    localparam logic [CNT_W-1:0]      c_cnt_one     = CNT_W'(1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_settle  = 3'd1;
    localparam logic [2:0] c_st_measure = 3'd2;
    localparam logic [2:0] c_st_decide  = 3'd3;
    localparam logic [2:0] c_st_locked  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [1:0]            r_cur;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic [CNT_W-1:0]      r_samp_cnt;
    logic                  r_mode;
    logic [1:0]            r_delay_sel;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_locked;
    logic [1:0]            r_best_sel;
    logic [CNT_W-1:0]      r_err_lead;
    logic [CNT_W-1:0]      r_err_orig;
    logic [CNT_W-1:0]      r_err_lag;

    logic                  w_abort;
    logic                  w_go;
    logic                  w_settle_done;
    logic                  w_meas_last;
    logic                  w_track_trig;
    logic [1:0]            w_best_sel;
    logic [CNT_W-1:0]      w_best_err;

    // ------------------------------------------------------------------
    // Control strobes and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // abort in IDLE is a no-op; elsewhere it always returns to IDLE
        w_abort       = abort && (r_state != c_st_idle);
        w_go          = ((r_state == c_st_idle) || (r_state == c_st_locked)) &&
                        !abort && (start || w_track_trig);
        w_settle_done = (r_state == c_st_settle) && (r_settle_cnt == c_settle_last);
        w_meas_last   = (r_state == c_st_measure) && sample_vld &&
                        (r_samp_cnt == c_meas_last);

        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:    if (w_go) w_state_nxt = c_st_settle;
                c_st_settle:  if (w_settle_done) w_state_nxt = c_st_measure;
                c_st_measure: if (w_meas_last)
                                  w_state_nxt = (r_cur == 2'd2) ? c_st_decide : c_st_settle;
                c_st_decide:  w_state_nxt = c_st_locked;
                c_st_locked:  if (w_go) w_state_nxt = c_st_settle;
                default:      w_state_nxt = c_st_idle;
            endcase
        end
    end

    // Minimum search; origin is the starting candidate and only a strictly
    // smaller count displaces it, giving the origin > leading > lagging order.
    always_comb begin
        w_best_sel = 2'd1;
        w_best_err = r_err_orig;
        if (r_err_lead < w_best_err) begin
            w_best_sel = 2'd0;
            w_best_err = r_err_lead;
        end
        if (r_err_lag < w_best_err) begin
            w_best_sel = 2'd2;
            w_best_err = r_err_lag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur        <= 2'd0;
            r_settle_cnt <= '0;
            r_samp_cnt   <= '0;
            r_mode       <= 1'b0;
            r_delay_sel  <= 2'd1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_locked     <= 1'b0;
            r_best_sel   <= 2'd1;
            r_err_lead   <= '0;
            r_err_orig   <= '0;
            r_err_lag    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_mode      <= 1'b0;
                r_delay_sel <= 2'd1;
                r_busy      <= 1'b0;
                r_locked    <= 1'b0;
            end else if (w_go) begin
                r_cur        <= 2'd0;
                r_settle_cnt <= '0;
                r_samp_cnt   <= '0;
                r_mode       <= 1'b1;
                r_delay_sel  <= 2'd0;
                r_busy       <= 1'b1;
                r_locked     <= 1'b0;
                r_err_lead   <= '0;
                r_err_orig   <= '0;
                r_err_lag    <= '0;
            end else begin
                case (r_state)
                    c_st_settle: begin
                        if (!w_settle_done) begin
                            r_settle_cnt <= r_settle_cnt + c_settle_one;
                        end
                    end
                    c_st_measure: begin
                        if (sample_vld) begin
                            if (sample_err) begin
                                case (r_cur)
                                    2'd0:    r_err_lead <= r_err_lead + c_cnt_one;
                                    2'd1:    r_err_orig <= r_err_orig + c_cnt_one;
                                    default: r_err_lag  <= r_err_lag + c_cnt_one;
                                endcase
                            end
                            if (w_meas_last) begin
                                r_samp_cnt   <= '0;
                                r_settle_cnt <= '0;
                                if (r_cur != 2'd2) begin
                                    r_cur       <= r_cur + 2'd1;
                                    r_delay_sel <= r_cur + 2'd1;
                                end
                            end else begin
                                r_samp_cnt <= r_samp_cnt + c_cnt_one;
                            end
                        end
                    end
                    c_st_decide: begin
                        r_best_sel  <= w_best_sel;
                        r_delay_sel <= w_best_sel;
                        r_mode      <= 1'b1;
                        r_locked    <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Locked-state error tracking
    // ------------------------------------------------------------------
`ifdef VAR_DELAY_TRACK_EN
    logic [CNT_W-1:0] r_win_samp;
    logic [CNT_W-1:0] r_win_err;

    // Trigger on the sample that pushes the window count past the threshold
    assign w_track_trig = (r_state == c_st_locked) && sample_vld && sample_err &&
                          ((int'(r_win_err) + 1) > ERR_THR);

    // Held clear outside LOCKED so each LOCKED entry starts a fresh window
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_st_locked)) begin
            r_win_samp <= '0;
            r_win_err  <= '0;
        end else if (sample_vld) begin
            if (w_track_trig || (r_win_samp == c_meas_last)) begin
                r_win_samp <= '0;
                r_win_err  <= '0;
            end else begin
                r_win_samp <= r_win_samp + c_cnt_one;
                if (sample_err) begin
                    r_win_err <= r_win_err + c_cnt_one;
                end
            end
        end
    end
`else
    localparam int c_unused_err_thr = ERR_THR;
    assign w_track_trig = 1'b0;
`endif

    assign mode      = r_mode;
    assign delay_sel = r_delay_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign locked    = r_locked;
    assign best_sel  = r_best_sel;
    assign err_lead  = r_err_lead;
    assign err_orig  = r_err_orig;
    assign err_lag   = r_err_lag;

endmodule
`default_nettype wire
